// File: rtl/amm_cfg_master_if.sv
// Avalon-MM bus bundle shared by the configuration master and its register slave.
interface avalon_mm_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] address;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              read;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, write, writedata, read,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, write, writedata, read,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/amm_cfg_master.sv
// Avalon-MM configuration master: loads pattern words into slave registers
// 1..PAT_WIDTH, then the control register 0 (enable), and optionally reads
// everything back in address order, flagging differences and lost responses.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start_i; inputs latched on start
// WRITE   | writing pattern words (index 1..PAT_WIDTH), then control word (0)
// READ    | issuing a read of register 'index'
// RD_WAIT | one read outstanding, waiting for readdatavalid or timeout
// DONE    | one-cycle done pulse, back to IDLE
module amm_cfg_master #(
    parameter int REG_WIDTH = 32,
    parameter int REG_DEPTH = 4,
    parameter int PAT_WIDTH = REG_DEPTH - 1,
    parameter int TIMEOUT   = 16
) (
    input  logic                                clk_i,
    input  logic                                srst_i,
    avalon_mm_if.master                         amm_master_if,
    input  logic                                start_i,
    input  logic                                verify_i,
    input  logic                                enable_i,
    input  logic [PAT_WIDTH-1:0][REG_WIDTH-1:0] pattern_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                mismatch_o,
    output logic                                timeout_o
);
    localparam int IW = (PAT_WIDTH < 1) ? 1 : $clog2(PAT_WIDTH + 1);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WRITE, READ, RD_WAIT, DONE} state_t;

    state_t                             state_q, state_d;
    logic [IW-1:0]                      idx_q, idx_d;
    logic [PAT_WIDTH-1:0][REG_WIDTH-1:0] pat_q, pat_d;
    logic                               en_q, en_d;
    logic                               ver_q, ver_d;
    logic                               mis_q, mis_d;
    logic                               to_q, to_d;
    logic [TW-1:0]                      tcnt_q, tcnt_d;
    logic [REG_WIDTH-1:0]               exp_word;
    logic                               last_idx;
    logic                               rd_match;

    // Word that belongs at the current index: control word at 0, pattern above.
    always_comb begin
        exp_word = '0;
        if (idx_q == '0) begin
            exp_word[0] = en_q;
        end
        for (int k = 0; k < PAT_WIDTH; k++) begin
            if (idx_q == IW'(k + 1)) begin
                exp_word = pat_q[k];
            end
        end
    end

    assign last_idx = (idx_q == IW'(PAT_WIDTH));
    assign rd_match = (amm_master_if.readdata == exp_word);

    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign mismatch_o = mis_q;
    assign timeout_o  = to_q;

    // State and latched-sequence registers.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pat_q   <= '0;
            en_q    <= 1'b0;
            ver_q   <= 1'b0;
            mis_q   <= 1'b0;
            to_q    <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pat_q   <= pat_d;
            en_q    <= en_d;
            ver_q   <= ver_d;
            mis_q   <= mis_d;
            to_q    <= to_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Next-state logic and bus drive; address/data are held from registers,
    // so they stay stable for as long as waitrequest stalls a transfer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pat_d   = pat_q;
        en_d    = en_q;
        ver_d   = ver_q;
        mis_d   = mis_q;
        to_d    = to_q;
        tcnt_d  = tcnt_q;
        amm_master_if.address   = '0;
        amm_master_if.write     = 1'b0;
        amm_master_if.writedata = '0;
        amm_master_if.read      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    pat_d   = pattern_i;
                    en_d    = enable_i;
                    ver_d   = verify_i;
                    mis_d   = 1'b0;
                    to_d    = 1'b0;
                    idx_d   = IW'(1);
                    state_d = WRITE;
                end
            end
            WRITE: begin
                amm_master_if.write     = 1'b1;
                amm_master_if.address   = REG_DEPTH'(idx_q);
                amm_master_if.writedata = exp_word;
                if (!amm_master_if.waitrequest) begin
                    if (idx_q == '0) begin
                        state_d = ver_q ? READ : DONE;
                    end else if (last_idx) begin
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            READ: begin
                amm_master_if.read    = 1'b1;
                amm_master_if.address = REG_DEPTH'(idx_q);
                if (!amm_master_if.waitrequest) begin
                    if (amm_master_if.readdatavalid) begin
                        // zero-latency slave: response belongs to this read
                        if (!rd_match) begin
                            mis_d = 1'b1;
                        end
                        if (last_idx) begin
                            state_d = DONE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        state_d = RD_WAIT;
                        tcnt_d  = '0;
                    end
                end
            end
            RD_WAIT: begin
                if (amm_master_if.readdatavalid) begin
                    if (!rd_match) begin
                        mis_d = 1'b1;
                    end
                    if (last_idx) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = READ;
                    end
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    to_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_amm_cfg_master.sv
// Randomized scoreboard bench for amm_cfg_master with a register-slave model.
module tb_amm_cfg_master;
    localparam int P  = 3;
    localparam int TO = 16;
    localparam int KW = 1, KR = 2, KD = 3;

    typedef struct {
        int          kind;
        logic [3:0]  addr;
        logic [31:0] data;
        logic        mis;
        logic        to;
        int          cyc;
    } ev_t;

    logic clk = 1'b0;
    logic srst, start, verify, enable;
    logic [P-1:0][31:0] pattern;
    logic busy_o, done_o, mismatch_o, timeout_o;

    avalon_mm_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    amm_cfg_master #(.REG_WIDTH(32), .REG_DEPTH(4), .PAT_WIDTH(P), .TIMEOUT(TO)) dut (
        .clk_i(clk), .srst_i(srst), .amm_master_if(bus),
        .start_i(start), .verify_i(verify), .enable_i(enable), .pattern_i(pattern),
        .busy_o(busy_o), .done_o(done_o), .mismatch_o(mismatch_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int ncyc = 0;
    ev_t q[$];
    bit sb_off = 0;
    int lat_mode = 1, corrupt = -1, stall_a = -1, stall_len = 0, stall_cnt = 0, w_a3 = 0;
    bit noresp = 0, rnd_stall = 0, noise = 0;
    logic [31:0] regs [16];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [3:0] a);
        return regs[a] ^ ((corrupt == int'(a)) ? 32'h0000_0100 : 32'h0);
    endfunction

    // Slave model: one-cycle or zero-cycle read latency, optional stalls and stray valids.
    initial begin
        logic acc_w, acc_r;
        logic [3:0] a;
        logic [31:0] d;
        for (int i = 0; i < 16; i++) regs[i] = '0;
        bus.waitrequest = 1'b0; bus.readdatavalid = 1'b0; bus.readdata = '0;
        forever begin
            @(negedge clk);
            acc_w = bus.write && !bus.waitrequest;
            acc_r = bus.read && !bus.waitrequest;
            a = bus.address; d = bus.writedata;
            @(posedge clk); #1;
            bus.readdatavalid = 1'b0; bus.readdata = '0;
            if (acc_w) regs[a] = d;
            if (acc_r && lat_mode == 1 && !noresp) begin
                bus.readdatavalid = 1'b1; bus.readdata = rd_word(a);
            end
            if (bus.write && int'(bus.address) == stall_a && stall_cnt < stall_len) begin
                bus.waitrequest = 1'b1; stall_cnt++;
            end else if (rnd_stall) begin
                bus.waitrequest = ($urandom_range(0, 2) == 0);
            end else begin
                bus.waitrequest = 1'b0;
            end
            if (lat_mode == 0 && bus.read && !bus.waitrequest && !noresp) begin
                bus.readdatavalid = 1'b1; bus.readdata = rd_word(bus.address);
            end
            if (noise && bus.write && !bus.readdatavalid) begin
                bus.readdatavalid = 1'($urandom); bus.readdata = $urandom;
            end
        end
    end

    // Monitor: matches every accepted transfer and done pulse against the queue.
    initial begin
        ev_t e;
        bit pw = 0, pr = 0;
        logic [3:0] pa = '0;
        logic [31:0] pd = '0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (pw) chk("hold_write", {bus.write, bus.address, bus.writedata}, {1'b1, pa, pd});
            if (pr) chk("hold_read", {bus.read, bus.address}, {1'b1, pa});
            pw = !srst && bus.write && bus.waitrequest;
            pr = !srst && bus.read && bus.waitrequest;
            pa = bus.address; pd = bus.writedata;
            if (bus.read || bus.write) chk("rd_wr_exclusive", {bus.read, bus.write} == 2'b11, 0);
            if (bus.write && bus.address == 4'd3) w_a3++;
            if (!srst && !sb_off && bus.write && !bus.waitrequest) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_write actual=addr %0d required=none", bus.address);
                end else begin
                    e = q.pop_front();
                    chk("write_addr", {KW, bus.address}, {e.kind, e.addr});
                    chk("write_data", bus.writedata, e.data);
                end
            end
            if (!srst && !sb_off && bus.read && !bus.waitrequest) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_read actual=addr %0d required=none", bus.address);
                end else begin
                    e = q.pop_front();
                    chk("read_addr", {KR, bus.address}, {e.kind, e.addr});
                end
            end
            if (done_o) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    e = q.pop_front();
                    chk("done_flags", {KD, busy_o, mismatch_o, timeout_o}, {e.kind, 1'b1, e.mis, e.to});
                    if (e.cyc >= 0) chk("done_cycle", ncyc, e.cyc);
                end
            end
        end
    end

    // Reference model: expected transfer list from the sequencing rules and slave mode.
    task automatic start_seq(input logic [P-1:0][31:0] pat, input logic en, input logic ver,
                             input int extra);
        ev_t e;
        int c, rd;
        logic mis, to;
        @(posedge clk); #1;
        c = ncyc;
        pattern = pat; enable = en; verify = ver; start = 1'b1;
        for (int k = 1; k <= P; k++) begin
            e = '{KW, 4'(k), pat[k-1], 1'b0, 1'b0, 0}; q.push_back(e);
        end
        e = '{KW, 4'd0, {31'b0, en}, 1'b0, 1'b0, 0}; q.push_back(e);
        rd = 0; mis = 1'b0; to = 1'b0;
        if (ver) begin
            if (noresp) begin
                e = '{KR, 4'd0, 32'd0, 1'b0, 1'b0, 0}; q.push_back(e);
                rd = 1 + TO; to = 1'b1;
            end else begin
                for (int a = 0; a <= P; a++) begin
                    e = '{KR, 4'(a), 32'd0, 1'b0, 1'b0, 0}; q.push_back(e);
                    if (corrupt == a) mis = 1'b1;
                    rd += (lat_mode == 0) ? 1 : 2;
                end
            end
        end
        e = '{KD, 4'd0, 32'd0, mis, to, (extra < 0) ? -1 : c + 2 + (P + 1) + rd + extra};
        q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0; verify = 1'($urandom); enable = 1'($urandom);
        for (int k = 0; k < P; k++) pattern[k] = $urandom;
        @(negedge clk);
        chk("start_busy_flags_clear", {busy_o, mismatch_o, timeout_o}, 3'b100);
    endtask

    task automatic finish_seq(input string nm);
        bit got = 0;
        for (int i = 0; i < 600 && !got; i++) begin
            @(negedge clk);
            got = done_o;
        end
        chk({nm, "_done_seen"}, got, 1);
        @(negedge clk);
        chk({nm, "_done_one_cycle"}, {done_o, busy_o}, 2'b00);
        chk({nm, "_sb_empty"}, q.size(), 0);
    endtask

    initial begin
        logic [P-1:0][31:0] p;
        bit seen;
        srst = 1'b1; start = 1'b0; verify = 1'b0; enable = 1'b0; pattern = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_bus", {bus.address, bus.write, bus.read, bus.writedata}, 0);
        chk("reset_status", {busy_o, done_o, mismatch_o, timeout_o}, 0);
        @(posedge clk); #1 srst = 1'b0;

        p[0] = 32'hA0; p[1] = 32'hB1; p[2] = 32'hC2;
        start_seq(p, 1'b1, 1'b0, 0); finish_seq("noverify");
        start_seq(p, 1'b1, 1'b1, 0); finish_seq("verify");

        corrupt = 2;
        start_seq(p, 1'b0, 1'b1, 0); finish_seq("corrupt");
        repeat (3) @(negedge clk);
        chk("mismatch_sticky", {mismatch_o, busy_o}, 2'b10);
        corrupt = -1;
        start_seq(p, 1'b1, 1'b1, 0); finish_seq("clean_after_corrupt");

        stall_a = 3; stall_len = 3; stall_cnt = 0; w_a3 = 0;
        start_seq(p, 1'b1, 1'b0, 3); finish_seq("stall_a3");
        chk("stall_a3_cycles", w_a3, 4);
        stall_len = 0;

        lat_mode = 0; noise = 1;
        start_seq(p, 1'b1, 1'b1, 0); finish_seq("lat0_noise");
        lat_mode = 1; noise = 0;

        noresp = 1;
        start_seq(p, 1'b1, 1'b1, 0); finish_seq("noresp");
        chk("timeout_sticky", {timeout_o, mismatch_o}, 2'b10);
        noresp = 0;

        // reset while a write is stalled; flags from the timeout run must clear
        sb_off = 1; stall_a = 2; stall_len = 20; stall_cnt = 0;
        @(posedge clk); #1 start = 1'b1; verify = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.write && bus.address == 4'd2 && bus.waitrequest;
        end
        chk("rst_stall_reached", seen, 1);
        @(posedge clk); #1 srst = 1'b1;
        @(posedge clk); #1 srst = 1'b0; stall_len = 0;
        @(negedge clk);
        chk("midrst_bus", {bus.address, bus.write, bus.read, bus.writedata}, 0);
        chk("midrst_status", {busy_o, done_o, mismatch_o, timeout_o}, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_no_done", {done_o, busy_o}, 0);
        end
        q.delete(); sb_off = 0;
        p[0] = 32'h1234_5678; p[1] = 32'h9ABC_DEF0; p[2] = 32'h0F0F_F0F0;
        start_seq(p, 1'b0, 1'b1, 0); finish_seq("first_after_reset");

        // start pulses while busy must be ignored
        start_seq(p, 1'b1, 1'b1, 0);
        @(posedge clk); #1 start = 1'b1; verify = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        finish_seq("busy_start");
        repeat (12) @(negedge clk);
        chk("busy_start_idle", {busy_o, q.size() == 0}, 2'b01);

        for (int n = 0; n < 25; n++) begin
            int cr;
            for (int k = 0; k < P; k++) p[k] = $urandom;
            lat_mode = int'($urandom_range(0, 1));
            rnd_stall = 1'($urandom);
            noise = 1'($urandom);
            cr = int'($urandom_range(0, 6));
            corrupt = (cr > 3) ? -1 : cr;
            noresp = ($urandom_range(0, 5) == 0);
            start_seq(p, 1'($urandom), 1'($urandom), rnd_stall ? -1 : 0);
            finish_seq("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/amm_cfg_master.md
AMM_CFG_MASTER -- requirements
Module: amm_cfg_master

Interface
REQ-001 The block SHALL have parameter REG_WIDTH, default 32, meaning Avalon-MM data width and pattern word width.
REQ-002 The block SHALL have parameter REG_DEPTH, default 4, meaning the number of slave registers; word addresses run 0..REG_DEPTH-1.
REQ-003 The block SHALL have parameter PAT_WIDTH, default REG_DEPTH-1, meaning the number of pattern words.
REQ-004 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum wait in cycles for readdatavalid after a read is accepted.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 The block SHALL have port srst_i, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have port amm_master_if, avalon_mm_if.master, carrying: address (REG_DEPTH bits) out, write out, writedata (REG_WIDTH bits) out, read out, waitrequest in, readdata (REG_WIDTH bits) in, readdatavalid in.
REQ-008 The block SHALL have port start_i, input, 1 bit: request one configuration sequence.
REQ-009 The block SHALL have port verify_i, input, 1 bit: when sampled high with start_i, read back and compare after writing.
REQ-010 The block SHALL have port enable_i, input, 1 bit: value written to control register bit 0.
REQ-011 The block SHALL have port pattern_i, input, array of PAT_WIDTH words of REG_WIDTH bits: key-symbol words.
REQ-012 The block SHALL have port busy_o, output, 1 bit: a sequence is in progress.
REQ-013 The block SHALL have port done_o, output, 1 bit: one-cycle pulse at sequence end.
REQ-014 The block SHALL have port mismatch_o, output, 1 bit: sticky flag, read-back differed.
REQ-015 The block SHALL have port timeout_o, output, 1 bit: sticky flag, readdatavalid did not arrive in time.

Function
REQ-016 The FSM SHALL have the states IDLE, WRITE, READ, RD_WAIT and DONE.
REQ-017 In IDLE, start_i=1 SHALL latch pattern_i, enable_i and verify_i, clear mismatch_o and timeout_o, and move to WRITE with the address index at 1.
REQ-018 start_i SHALL be ignored in every state other than IDLE.
REQ-019 WRITE SHALL drive write=1, address=index and writedata=the latched pattern word index-1 for indices 1..PAT_WIDTH, then index 0 with writedata={zeros, enable}.
REQ-020 The control register (address 0) SHALL be written last, so the slave enables only after the full pattern is loaded.
REQ-021 A write SHALL be accepted on a cycle with write=1 and waitrequest=0; while waitrequest=1, address, writedata and write SHALL hold stable.
REQ-022 After address 0 is accepted, the FSM SHALL go to READ (index 0) if verify was latched high, otherwise to DONE.
REQ-023 READ SHALL drive read=1 and address=index; on acceptance (waitrequest=0) it SHALL go to RD_WAIT with the timeout counter cleared.
REQ-024 Only one read SHALL be outstanding at a time, and read SHALL be low in RD_WAIT.
REQ-025 In RD_WAIT, readdatavalid=1 SHALL compare readdata against the expected word (index 0: {zeros, enable}; index k: pattern word k-1) and set mismatch_o on any difference.
REQ-026 After a compare, the index SHALL advance; after index PAT_WIDTH the FSM SHALL go to DONE, otherwise back to READ.
REQ-027 readdatavalid arriving in the same cycle the read is accepted SHALL be captured as the response to that read.
REQ-028 In RD_WAIT, TIMEOUT cycles without readdatavalid SHALL set timeout_o and move to DONE, skipping the remaining reads.
REQ-029 DONE SHALL assert done_o for exactly one cycle and then return to IDLE.
REQ-030 busy_o SHALL be 1 in every state except IDLE.
REQ-031 read and write SHALL never be asserted in the same cycle.
REQ-032 readdatavalid outside RD_WAIT SHALL be ignored.
REQ-033 Minimum sequence length with no wait states: PAT_WIDTH+1 write cycles, plus 2*(PAT_WIDTH+1) read cycles when verify is set, plus 1 DONE cycle.

Reset
REQ-034 srst_i=1 SHALL force IDLE and drive read, write, busy_o, done_o, mismatch_o and timeout_o to 0, and address and writedata to 0.
REQ-035 Reset during any state, including mid-transfer under waitrequest, SHALL abort the sequence on the next edge with no done_o pulse.
REQ-036 The first start_i after reset release SHALL be accepted.

Verification
REQ-037 No-verify case: enable_i=1, pattern words A0/B1/C2, waitrequest=0 -> writes to addresses 1, 2, 3 with data A0, B1, C2, then address 0 with data 1; done_o pulses on cycle 5; flags both 0.
REQ-038 Verify against a one-cycle-latency register slave model -> 4 reads in order 0, 1, 2, 3; mismatch_o=0; done_o pulses once.
REQ-039 Slave model corrupts address 2 read data -> mismatch_o=1 at done_o and held until the next start.
REQ-040 waitrequest held high 3 cycles on the address 3 write -> address and data stay stable for 4 cycles; write is accepted exactly once.
REQ-041 Slave never returns readdatavalid -> timeout_o=1 after 16 RD_WAIT cycles; done_o pulses; no further reads are issued.
REQ-042 srst_i pulsed during WRITE, and start_i pulsed while busy -> reset: IDLE with all outputs 0 and no done_o; busy: the start is ignored and no second sequence runs.
